param_up_down_counter: RTL and testbench

PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

---
 rtl/param_up_down_counter_if.sv | 28 ++
 rtl/param_up_down_counter.sv | 173 +++++++++++++++++
 tb/tb_param_up_down_counter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_up_down_counter_if.sv
// Bus, control and status signals of the programmable up/down counter.
interface param_up_down_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ncs;
    logic             nwr;
    logic             nrd;
    logic [2:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             ec;
    logic             err;
    logic             busy;

    modport master (
        output ncs, nwr, nrd, addr, din, start, stop,
        input  dout, count, dir, ec, err, busy
    );

    modport slave (
        input  ncs, nwr, nrd, addr, din, start, stop,
        output dout, count, dir, ec, err, busy
    );
endinterface

// File: rtl/param_up_down_counter.sv
// Programmable up/down counter bouncing between LLR and ULR with a register
// bus, cycle counting (or continuous mode) and sticky configuration error.
module param_up_down_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CCR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    param_up_down_counter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_plr;
    logic [WIDTH-1:0]     r_ulr;
    logic [WIDTH-1:0]     r_llr;
    logic [CCR_WIDTH-1:0] r_ccr;
    logic [WIDTH-1:0]     r_step;
    logic [1:0]           r_mode;
    logic [WIDTH-1:0]     r_count;
    logic [CCR_WIDTH-1:0] r_cycles;
    logic                 r_dir;
    logic                 r_ec;
    logic                 r_err;
    logic [WIDTH-1:0]     r_dout;

    logic                 w_busy;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_valid;
    logic                 w_load_dir;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic                 w_up_hit;
    logic                 w_dn_hit;
    logic [WIDTH-1:0]     w_count_step;
    logic                 w_run_step;
    logic                 w_arrival;
    logic [CCR_WIDTH-1:0] w_cycles_dec;
    logic                 w_last;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [WIDTH-1:0]     w_rd_data;

    // Control decode, validation and next-count arithmetic
    always_comb begin
        w_busy     = (r_state == ST_RUN);
        w_start    = bus.start & ~bus.ncs;
        w_stop     = bus.stop & ~bus.ncs & w_busy;
        w_valid    = !((r_llr >= r_ulr) || (r_plr < r_llr) || (r_plr > r_ulr) ||
                       (r_step == '0) || ((r_ccr == '0) && !r_mode[1]));
        // Starting at a limit forces the direction away from it
        if (r_plr == r_ulr)
            w_load_dir = 1'b0;
        else if (r_plr == r_llr)
            w_load_dir = 1'b1;
        else
            w_load_dir = ~r_mode[0];
        // One extra bit keeps the arithmetic from wrapping before clipping
        w_sum        = {1'b0, r_count} + {1'b0, r_step};
        w_diff       = {1'b0, r_count} - {1'b0, r_step};
        w_up_hit     = (w_sum >= {1'b0, r_ulr});
        w_dn_hit     = w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= r_llr);
        if (r_dir)
            w_count_step = w_up_hit ? r_ulr : w_sum[WIDTH-1:0];
        else
            w_count_step = w_dn_hit ? r_llr : w_diff[WIDTH-1:0];
        w_run_step   = w_busy && !w_start && !w_stop;
        w_arrival    = w_run_step && !r_dir && w_dn_hit;
        w_cycles_dec = r_cycles - 1'b1;
        w_last       = w_arrival && !r_mode[1] && (w_cycles_dec == '0);
        w_wr_en      = !w_busy && !bus.ncs && !bus.nwr && bus.nrd;
        w_rd_en      = !bus.ncs && !bus.nrd && bus.nwr;
    end

    // Register read multiplexer, zero-extended to the bus width
    always_comb begin
        w_rd_data = '0;
        case (bus.addr)
            3'd0:    w_rd_data = r_plr;
            3'd1:    w_rd_data = r_ulr;
            3'd2:    w_rd_data = r_llr;
            3'd3:    w_rd_data = WIDTH'(r_ccr);
            3'd4:    w_rd_data = r_step;
            3'd5:    w_rd_data = WIDTH'(r_mode);
            3'd6:    w_rd_data = r_count;
            default: w_rd_data = WIDTH'({w_busy, r_err, r_ec, r_dir});
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: start wins over stop and over counting
    always_comb begin
        w_state_next = r_state;
        if (w_start)
            w_state_next = w_valid ? ST_RUN : ST_IDLE;
        else if (w_stop || w_last)
            w_state_next = ST_IDLE;
    end

    // Output drive
    always_comb begin
        bus.busy  = w_busy;
        bus.count = r_count;
        bus.dir   = r_dir;
        bus.ec    = r_ec;
        bus.err   = r_err;
        bus.dout  = r_dout;
    end

    // Configuration registers, read data and counting datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_plr    <= '0;
            r_ulr    <= '1;
            r_llr    <= '0;
            r_ccr    <= CCR_WIDTH'(1);
            r_step   <= WIDTH'(1);
            r_mode   <= '0;
            r_count  <= '0;
            r_cycles <= '0;
            r_dir    <= 1'b1;
            r_ec     <= 1'b0;
            r_err    <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_ec   <= 1'b0;
            r_dout <= w_rd_en ? w_rd_data : '0;
            if (w_wr_en) begin
                case (bus.addr)
                    3'd0:    r_plr  <= bus.din;
                    3'd1:    r_ulr  <= bus.din;
                    3'd2:    r_llr  <= bus.din;
                    3'd3:    r_ccr  <= CCR_WIDTH'(bus.din);
                    3'd4:    r_step <= bus.din;
                    3'd5:    r_mode <= bus.din[1:0];
                    default: ;
                endcase
            end
            // Validation sees the pre-write register values of this edge
            if (w_start) begin
                if (w_valid) begin
                    r_err    <= 1'b0;
                    r_count  <= r_plr;
                    r_cycles <= r_ccr;
                    r_dir    <= w_load_dir;
                end else begin
                    r_err    <= 1'b1;
                end
            end else if (w_run_step) begin
                r_count <= w_count_step;
                if (r_dir && w_up_hit)
                    r_dir <= 1'b0;
                if (w_arrival) begin
                    r_ec <= 1'b1;
                    if (!r_mode[1])
                        r_cycles <= w_cycles_dec;
                    if (!w_last)
                        r_dir <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_up_down_counter.sv
// Scoreboard bench for param_up_down_counter at WIDTH=8 and WIDTH=12.
module tb_param_up_down_counter;
    typedef struct {
        logic [11:0] count;
        logic        ec;
        logic        busy;
        logic        dir;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    param_up_down_counter_if #(.WIDTH(8))  bus8 ();
    param_up_down_counter_if #(.WIDTH(12)) bus12 ();

    param_up_down_counter #(.WIDTH(8), .CCR_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave)
    );
    param_up_down_counter #(.WIDTH(12), .CCR_WIDTH(8)) dut12 (
        .clk(clk), .reset(reset), .bus(bus12.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus8.ncs = 1; bus8.nwr = 1; bus8.nrd = 1; bus8.addr = 0; bus8.din = 0;
        bus8.start = 0; bus8.stop = 0;
        bus12.ncs = 1; bus12.nwr = 1; bus12.nrd = 1; bus12.addr = 0; bus12.din = 0;
        bus12.start = 0; bus12.stop = 0;
    endtask

    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        bus8.ncs = 0; bus8.nwr = 0; bus8.nrd = 1; bus8.addr = a; bus8.din = d;
        tick();
        bus8.ncs = 1; bus8.nwr = 1;
    endtask

    task automatic rd8(input logic [2:0] a, output logic [7:0] d);
        bus8.ncs = 0; bus8.nrd = 0; bus8.nwr = 1; bus8.addr = a;
        tick();
        d = bus8.dout;
        bus8.ncs = 1; bus8.nrd = 1;
    endtask

    task automatic wr12(input logic [2:0] a, input logic [11:0] d);
        bus12.ncs = 0; bus12.nwr = 0; bus12.nrd = 1; bus12.addr = a; bus12.din = d;
        tick();
        bus12.ncs = 1; bus12.nwr = 1;
    endtask

    task automatic rd12(input logic [2:0] a, output logic [11:0] d);
        bus12.ncs = 0; bus12.nrd = 0; bus12.nwr = 1; bus12.addr = a;
        tick();
        d = bus12.dout;
        bus12.ncs = 1; bus12.nrd = 1;
    endtask

    task automatic start8();
        bus8.ncs = 0; bus8.start = 1;
        tick();
        bus8.ncs = 1; bus8.start = 0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1;
        tick();
        tick();
        reset = 0;
        total++; if (bus8.count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus8.count); end
        total++; if (bus8.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus8.err); end
        total++; if (bus8.ec !== 1'b0) begin bad++; $display("FAIL reset_ec got=%b want=0", bus8.ec); end
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus8.busy); end
        total++; if (bus8.dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", bus8.dir); end
        total++; if (bus8.dout !== 8'd0) begin bad++; $display("FAIL reset_dout got=%0d want=0", bus8.dout); end
        rd8(3'd1, v);
        total++; if (v !== 8'd255) begin bad++; $display("FAIL reset_ulr got=%0d want=255", v); end
        rd8(3'd3, v);
        total++; if (v !== 8'd1) begin bad++; $display("FAIL reset_ccr got=%0d want=1", v); end
    endtask

    task automatic test_basic_run();
        exp_t e;
        wr8(0, 10); wr8(1, 15); wr8(2, 5); wr8(3, 1); wr8(4, 1); wr8(5, 0);
        for (int i = 0; i < 16; i++) begin
            e.count = (i <= 5) ? 12'(10 + i) : 12'(15 - (i - 5));
            e.ec    = (i == 15);
            e.busy  = (i != 15);
            e.dir   = (i < 5);
            exp_q.push_back(e);
        end
        start8();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            total++; if ({4'h0, bus8.count} !== e.count) begin bad++; $display("FAIL basic_count[%0d] got=%0d want=%0d", i, bus8.count, e.count); end
            total++; if (bus8.ec !== e.ec) begin bad++; $display("FAIL basic_ec[%0d] got=%b want=%b", i, bus8.ec, e.ec); end
            total++; if (bus8.busy !== e.busy) begin bad++; $display("FAIL basic_busy[%0d] got=%b want=%b", i, bus8.busy, e.busy); end
            total++; if (bus8.dir !== e.dir) begin bad++; $display("FAIL basic_dir[%0d] got=%b want=%b", i, bus8.dir, e.dir); end
        end
        tick();
        total++; if (bus8.count !== 8'd5 || bus8.ec !== 1'b0 || bus8.busy !== 1'b0) begin
            bad++; $display("FAIL basic_after got=%0d/%b/%b want=5/0/0", bus8.count, bus8.ec, bus8.busy);
        end
    endtask

    task automatic test_step_clip();
        exp_t e;
        int unsigned seq[13] = '{5, 9, 13, 15, 11, 7, 5, 9, 13, 15, 11, 7, 5};
        wr8(0, 5); wr8(1, 15); wr8(2, 5); wr8(3, 2); wr8(4, 4); wr8(5, 0);
        for (int i = 0; i < 13; i++) begin
            e.count = 12'(seq[i]);
            e.ec    = (i == 6) || (i == 12);
            e.busy  = (i != 12);
            e.dir   = (i < 3) || (i >= 6 && i < 9);
            exp_q.push_back(e);
        end
        start8();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            total++; if ({4'h0, bus8.count} !== e.count) begin bad++; $display("FAIL clip_count[%0d] got=%0d want=%0d", i, bus8.count, e.count); end
            total++; if (bus8.ec !== e.ec) begin bad++; $display("FAIL clip_ec[%0d] got=%b want=%b", i, bus8.ec, e.ec); end
            total++; if (bus8.busy !== e.busy) begin bad++; $display("FAIL clip_busy[%0d] got=%b want=%b", i, bus8.busy, e.busy); end
            total++; if (bus8.dir !== e.dir) begin bad++; $display("FAIL clip_dir[%0d] got=%b want=%b", i, bus8.dir, e.dir); end
        end
    endtask

    task automatic test_error();
        wr8(2, 7); wr8(1, 5);
        start8();
        total++; if (bus8.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus8.err); end
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL err_busy got=%b want=0", bus8.busy); end
        total++; if (bus8.count !== 8'd5) begin bad++; $display("FAIL err_count got=%0d want=5", bus8.count); end
        wr8(2, 2);
        start8();
        total++; if (bus8.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus8.err); end
        total++; if (bus8.busy !== 1'b1) begin bad++; $display("FAIL err_run got=%b want=1", bus8.busy); end
        total++; if (bus8.dir !== 1'b0) begin bad++; $display("FAIL err_dir_at_ulr got=%b want=0", bus8.dir); end
        bus8.ncs = 0; bus8.stop = 1;
        tick();
        bus8.ncs = 1; bus8.stop = 0;
        total++; if (bus8.count !== 8'd5 || bus8.busy !== 1'b0 || bus8.ec !== 1'b0) begin
            bad++; $display("FAIL err_stop got=%0d/%b/%b want=5/0/0", bus8.count, bus8.busy, bus8.ec);
        end
    endtask

    task automatic test_start_stop();
        wr8(0, 3); wr8(1, 9); wr8(2, 1); wr8(3, 1); wr8(4, 2); wr8(5, 1);
        bus8.ncs = 0; bus8.start = 1; bus8.stop = 1;
        tick();
        bus8.ncs = 1; bus8.start = 0; bus8.stop = 0;
        total++; if (bus8.busy !== 1'b1 || bus8.count !== 8'd3 || bus8.dir !== 1'b0) begin
            bad++; $display("FAIL startstop got=%b/%0d/%b want=1/3/0", bus8.busy, bus8.count, bus8.dir);
        end
        tick();
        total++; if (bus8.count !== 8'd1 || bus8.ec !== 1'b1 || bus8.busy !== 1'b0) begin
            bad++; $display("FAIL down_clip got=%0d/%b/%b want=1/1/0", bus8.count, bus8.ec, bus8.busy);
        end
    endtask

    task automatic test_mid_run();
        logic [7:0] v;
        wr8(0, 10); wr8(1, 200); wr8(2, 0); wr8(3, 1); wr8(4, 1); wr8(5, 0);
        start8();
        total++; if (bus8.count !== 8'd10) begin bad++; $display("FAIL mid_start got=%0d want=10", bus8.count); end
        wr8(0, 20);
        total++; if (bus8.count !== 8'd11) begin bad++; $display("FAIL mid_wr_count got=%0d want=11", bus8.count); end
        rd8(3'd0, v);
        total++; if (v !== 8'd10) begin bad++; $display("FAIL mid_plr_rb got=%0d want=10", v); end
        total++; if (bus8.count !== 8'd12) begin bad++; $display("FAIL mid_rd_count got=%0d want=12", bus8.count); end
        for (int n = 3; n < 8; n++) begin
            tick();
            total++; if (bus8.count !== 8'(10 + n)) begin bad++; $display("FAIL mid_ncs_count[%0d] got=%0d want=%0d", n, bus8.count, 10 + n); end
        end
        bus8.ncs = 0; bus8.stop = 1;
        tick();
        bus8.ncs = 1; bus8.stop = 0;
        total++; if (bus8.count !== 8'd17 || bus8.busy !== 1'b0 || bus8.ec !== 1'b0 || bus8.dir !== 1'b1) begin
            bad++; $display("FAIL mid_stop got=%0d/%b/%b/%b want=17/0/0/1", bus8.count, bus8.busy, bus8.ec, bus8.dir);
        end
        bus8.start = 1;
        tick();
        bus8.start = 0;
        total++; if (bus8.busy !== 1'b0 || bus8.count !== 8'd17) begin
            bad++; $display("FAIL ncs_blocks_start got=%b/%0d want=0/17", bus8.busy, bus8.count);
        end
        start8();
        tick();
        tick();
        total++; if (bus8.count !== 8'd12 || bus8.busy !== 1'b1) begin
            bad++; $display("FAIL restart got=%0d/%b want=12/1", bus8.count, bus8.busy);
        end
        reset = 1;
        tick();
        reset = 0;
        total++; if (bus8.count !== 8'd0 || bus8.dir !== 1'b1 || bus8.busy !== 1'b0 ||
                     bus8.err !== 1'b0 || bus8.ec !== 1'b0 || bus8.dout !== 8'd0) begin
            bad++; $display("FAIL mid_reset got=%0d/%b/%b/%b/%b/%0d want=0/1/0/0/0/0",
                            bus8.count, bus8.dir, bus8.busy, bus8.err, bus8.ec, bus8.dout);
        end
        rd8(3'd0, v);
        total++; if (v !== 8'd0) begin bad++; $display("FAIL mid_reset_plr got=%0d want=0", v); end
    endtask

    task automatic test_continuous_w12();
        logic [11:0] v;
        exp_t e;
        logic [11:0] c;
        logic d;
        rd12(3'd1, v);
        total++; if (v !== 12'd4095) begin bad++; $display("FAIL w12_ulr got=%0d want=4095", v); end
        wr12(0, 0); wr12(1, 3); wr12(2, 0); wr12(3, 0); wr12(5, 2);
        c = 0; d = 1;
        e.count = c; e.ec = 0; e.busy = 1; e.dir = d;
        exp_q.push_back(e);
        for (int i = 1; i < 24; i++) begin
            e.ec = 0;
            if (d) begin
                c = c + 1;
                if (c == 12'd3) d = 0;
            end else begin
                c = c - 1;
                if (c == 12'd0) begin d = 1; e.ec = 1; end
            end
            e.count = c; e.busy = 1; e.dir = d;
            exp_q.push_back(e);
        end
        bus12.ncs = 0; bus12.start = 1;
        tick();
        bus12.ncs = 1; bus12.start = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            total++; if (bus12.count !== e.count) begin bad++; $display("FAIL w12_count[%0d] got=%0d want=%0d", i, bus12.count, e.count); end
            total++; if (bus12.ec !== e.ec) begin bad++; $display("FAIL w12_ec[%0d] got=%b want=%b", i, bus12.ec, e.ec); end
            total++; if (bus12.busy !== e.busy) begin bad++; $display("FAIL w12_busy[%0d] got=%b want=%b", i, bus12.busy, e.busy); end
        end
        bus12.ncs = 0; bus12.stop = 1;
        tick();
        bus12.ncs = 1; bus12.stop = 0;
        total++; if (bus12.busy !== 1'b0) begin bad++; $display("FAIL w12_stop got=%b want=0", bus12.busy); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_basic_run();
        test_step_clip();
        test_error();
        test_start_stop();
        test_mid_run();
        test_continuous_w12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
